grant_decoder: RTL
==================

# grant_decoder

- Decoding end of the priority-encoder path: accepts a 2-bit winning-requester code with a valid/ready handshake and drives a registered one-hot grant.
- Holds the grant until the granted requester returns `done`, then inserts a one-cycle release gap before accepting the next code.
- Sits between the priority encoder (with its `or4` any-request detect) and the four requesters.
- Optional watchdog revokes a grant that is held too long.

## Interface
- `TIMEOUT`, 15, grant hold limit in cycles (watchdog builds only); legal range 1..2^`TIMEOUT_W`-1
- `TIMEOUT_W`, 4, width of the watchdog counter
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset; asynchronous, active-low
- `code`  input  2  index of the requester to grant
- `code_valid`  input  1  `code` is valid
- `code_ready`  output  1  block can accept a code; equals `state==IDLE`
- `done`  input  4  per-requester release; only the bit matching the granted index is honoured
- `grant`  output  4  registered one-hot grant
- `busy`  output  1  registered; 1 in GRANT and RELEASE
- `timeout`  output  1  registered one-cycle pulse when the watchdog revokes a grant

## Operation
- **States:** IDLE, GRANT, RELEASE. Encoding is free.
- **Reset** (asynchronous, `rst_n` low), effective immediately:
  - state=IDLE
  - `grant`=4'b0000, `busy`=0, `timeout`=0
  - latched index=0, watchdog counter=0
  - `code_ready` reads 1; inputs are ignored while `rst_n` is low.
- **IDLE:**
  - On `code_valid` & `code_ready`: latch `code`, set `grant`<=1<<`code`, `busy`<=1, clear the counter, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - `code_ready`=0; `code`/`code_valid` are ignored.
  - If `done[idx]`=1: `grant`<=0, go to RELEASE.
  - `done` bits other than `idx` have no effect.
- **RELEASE:** exactly one cycle, `grant`=0 and `busy`=1. Then go to IDLE with `busy`<=0.
- **Arithmetic:** `grant` is always 0 or exactly one-hot. Bit `i` is set only for `code`=i. No other encodings exist, since `code` is 2 bits.
- **Reset mid-operation:** a `rst_n` assertion in any state drops `grant` immediately. No `timeout` pulse is produced.

## Timing
- **Latency:** `grant` rises at the clock edge that accepts the code, so it is visible the cycle after the handshake.
- **Back-to-back codes:** minimum spacing between accepts is 3 cycles when `done` returns on the first GRANT cycle (accept, GRANT, RELEASE, accept).
- **Release:** `done[idx]` high during a GRANT cycle clears `grant` at that cycle's edge. `done` held high past the release is harmless.
- **Handshake:** `code_valid` may be held across non-ready cycles. The code present in the first IDLE cycle is the one taken.

## Configuration
- Macro: `GRANT_DECODER_TIMEOUT_EN`.
- **Defined:**
  - Counter clears on entry to GRANT and increments each GRANT cycle without `done[idx]`.
  - In a GRANT cycle where the counter equals `TIMEOUT`-1 and `done[idx]`=0, the edge sets `grant`<=0, `timeout`<=1 for one cycle, and goes to RELEASE.
  - `grant` is therefore high for exactly `TIMEOUT` cycles.
  - If `done[idx]` and expiry coincide, `done` wins: no `timeout` pulse.
- **Undefined:**
  - No counter logic is built; `TIMEOUT` and `TIMEOUT_W` are unused.
  - `timeout` is tied to 0.
  - GRANT is held indefinitely until `done[idx]`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-GRANT with `grant`=4'b0100 -> `grant`=0, `busy`=0, `timeout`=0 immediately, and `code_ready`=1.
- **Basic grant:** `code`=2'b10 with `code_valid` at cycle 0 -> `grant`=4'b0100 and `busy`=1 from cycle 1. Pulse `done`=4'b0100 at cycle 3 -> `grant`=0 at cycle 4; `busy`=0 and `code_ready`=1 at cycle 5.
- **Wrong done:** grant index 1, drive `done`=4'b1101 for 5 cycles -> `grant` stays 4'b0010. Then `done`=4'b0010 -> release on the next edge.
- **Back-to-back:** codes 3, 0, 1 held valid continuously, with `done` returned in the first GRANT cycle -> grants 4'b1000, 4'b0001, 4'b0010, one accept every 3 cycles, with a one-cycle `grant`=0 gap between grants.
- **Watchdog** (macro defined, `TIMEOUT`=4, no `done`) -> `grant` high exactly 4 cycles, `timeout`=1 for one cycle as `grant` falls, then IDLE. Repeat with `done[idx]` on the 4th cycle -> `timeout` stays 0.
- **No watchdog** (macro undefined) -> grant held for 100 cycles with `timeout`=0 throughout.

Source files
------------

// File: rtl/grant_decoder_if.sv
// grant_decoder_if: code handshake and grant bus between the priority encoder, the decoder and the requesters
interface grant_decoder_if;
    logic [1:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [3:0] done;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;
    modport master (output code, code_valid, done, input code_ready, grant, busy, timeout);
    modport slave (input code, code_valid, done, output code_ready, grant, busy, timeout);
endinterface

// File: rtl/grant_decoder.sv
// grant_decoder: registered one-hot grant from a 2-bit code, held until done, then a one-cycle release gap
// GRANT_DECODER_TIMEOUT_EN builds a watchdog that revokes a grant held for TIMEOUT cycles
module grant_decoder
`ifdef GRANT_DECODER_TIMEOUT_EN
#(
    parameter int TIMEOUT   = 15,
    parameter int TIMEOUT_W = 4
)
`endif
(
    input  logic           clk,
    input  logic           rst_n,
    grant_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t     state;
    logic [1:0] idx;
    logic [3:0] grant;
    logic       busy;
    logic       hit;
    assign hit            = bus.done[idx];
    assign bus.code_ready = state == IDLE;
    assign bus.grant      = grant;
    assign bus.busy       = busy;
`ifdef GRANT_DECODER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    logic                 timeout;
    logic                 expire;
    assign expire      = cnt == TIMEOUT_W'(TIMEOUT - 1);
    assign bus.timeout = timeout;
`else
    assign bus.timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            grant <= '0;
            busy  <= 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef GRANT_DECODER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE:
                    if (bus.code_valid) begin
                        idx   <= bus.code;
                        grant <= 4'b0001 << bus.code;
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef GRANT_DECODER_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end
                GRANT:
                    if (hit) begin
                        grant <= '0;
                        state <= RELEASE;
                    end
`ifdef GRANT_DECODER_TIMEOUT_EN
                    // done on the expiry cycle takes priority, so no timeout pulse then
                    else if (expire) begin
                        grant   <= '0;
                        timeout <= 1'b1;
                        state   <= RELEASE;
                    end else
                        cnt <= cnt + 1'b1;
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
endmodule
